// File: rtl/host_write_fifo_pkg.sv
// host_write_fifo_pkg: shared OPL3 register-write constants
package host_write_fifo_pkg;
  localparam int OPL3_ADDR_WIDTH = 9;
  localparam int OPL3_DATA_WIDTH = 8;
  localparam int OPL3_WRITE_GAP  = 32;
endpackage

// File: rtl/host_write_fifo_mem.sv
// host_write_fifo_mem: simple dual-port memory, synchronous write, asynchronous read
module host_write_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // write port; contents are never reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/host_write_fifo.sv
// host_write_fifo: buffers host register writes and drains them with a fixed minimum gap
module host_write_fifo
  import host_write_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = OPL3_ADDR_WIDTH,
  parameter int DATA_WIDTH = OPL3_DATA_WIDTH,
  parameter int WRITE_GAP  = OPL3_WRITE_GAP
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_wr,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int GW = $clog2(WRITE_GAP) + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] HOLDOFF = 1'b1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic [EW-1:0] head;
  logic [0:0]    state;
  logic          push, pop;
  // the drain state is fully encoded by the gap counter
  assign state    = (gap_cnt != '0) ? HOLDOFF : IDLE;
  // ready comes from the registered count only, so a same-cycle pop never frees a slot early
  assign in_ready = level != LW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (level != '0);
  host_write_fifo_mem #(
    .DATA_WIDTH(EW),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata({in_addr, in_data}),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // pointers wrap naturally; full/empty are decided by level alone
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      level  <= level + LW'(push) - LW'(pop);
    end
  // issue one head entry per gap window and hold off WRITE_GAP-1 cycles after it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gap_cnt  <= '0;
      out_wr   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_wr  <= pop;
      gap_cnt <= pop ? GW'(WRITE_GAP - 1) : (state == HOLDOFF) ? gap_cnt - GW'(1) : gap_cnt;
      if (pop) {out_addr, out_data} <= head;
    end
endmodule

// File: doc/host_write_fifo.md
HOST_WRITE_FIFO -- requirements
Module: host_write_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of buffered register writes; power of two, 2 or more.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: OPL3 register address width (bank bit plus 8).
REQ-003 SHALL have parameter DATA_WIDTH, default 8: register data width.
REQ-004 SHALL have parameter WRITE_GAP, default 32: minimum number of clk cycles between consecutive out_wr pulses; 1 or more.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: host presents a register write.
REQ-008 SHALL have port in_ready, output, 1 bit: FIFO can accept a write.
REQ-009 SHALL have port in_addr, input, ADDR_WIDTH bits: register address of the write.
REQ-010 SHALL have port in_data, input, DATA_WIDTH bits: register data of the write.
REQ-011 SHALL have port out_wr, output, 1 bit: one-cycle strobe into the register-file write port.
REQ-012 SHALL have port out_addr, output, ADDR_WIDTH bits: register address qualified by out_wr.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits: register data qualified by out_wr.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1 bits: current entry count.

Function
REQ-015 SHALL accept an entry on a rising edge where in_valid and in_ready are both high, storing {in_addr, in_data} at the write pointer.
REQ-016 SHALL drive in_ready as (level != DEPTH), taken from the registered count only. A pop in the same cycle SHALL NOT raise in_ready.
REQ-017 SHALL ignore in_valid while in_ready is low; the entry is not stored and no state changes.
REQ-018 SHALL keep a drain FSM with two states. IDLE means gap_cnt == 0. HOLDOFF means gap_cnt != 0.
REQ-019 In IDLE with level != 0, the block SHALL issue on the next edge: set out_wr=1, load out_addr/out_data from the head entry, advance the read pointer, and load gap_cnt = WRITE_GAP-1.
REQ-020 In HOLDOFF, the block SHALL decrement gap_cnt by one per cycle and SHALL NOT issue.
REQ-021 In IDLE with level == 0, the block SHALL hold out_wr=0. out_addr/out_data SHALL keep their last values.
REQ-022 Consecutive out_wr pulses SHALL be exactly WRITE_GAP cycles apart while the FIFO stays non-empty. With WRITE_GAP=1 the pulses SHALL be back-to-back.
REQ-023 out_wr SHALL be high for exactly one cycle per issued entry.
REQ-024 An entry accepted at edge e SHALL be issuable no earlier than edge e+1, because head data is read asynchronously from storage written at e.
REQ-025 On simultaneous push and issue, level SHALL stay unchanged. This includes level == 1, where the pushed entry is not the issued one.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty SHALL be resolved by level, not by pointer comparison.
REQ-027 Issue order SHALL equal acceptance order; no entry is dropped or duplicated.

Reset
REQ-028 While reset_n is low, the block SHALL asynchronously force: out_wr=0, out_addr=0, out_data=0, level=0, pointers=0, gap_cnt=0 (IDLE). in_ready SHALL be 1.
REQ-029 Reset mid-drain SHALL discard all buffered entries, and no out_wr SHALL follow reset release until a new entry is accepted.
REQ-030 Storage contents SHALL NOT be reset.

Structure
REQ-031 Entry storage SHALL be one instance of the team's simple dual-port async-read memory, DATA_WIDTH = ADDR_WIDTH + DATA_WIDTH, DEPTH = DEPTH. Its write port is driven by the accept logic and its read address by the read pointer.
REQ-032 The OPL3 register address/data widths and the default WRITE_GAP SHALL come from the shared OPL3 package. There SHALL be no local duplicate constants.
REQ-033 The FSM state type SHALL be local to the module; gap_cnt SHALL be $clog2(WRITE_GAP)+1 bits.

Verification (DEPTH=4, WRITE_GAP=3)
REQ-034 Single push 0x105/0xA5 at edge e -> out_wr high in the cycle after e+1 with out_addr=0x105, out_data=0xA5. level returns to 0.
REQ-035 Six back-to-back pushes 0x000..0x005 -> out_wr pulses exactly 3 cycles apart, in order 0x000..0x005.
REQ-036 in_valid held high for 10 entries -> in_ready low whenever level=4. All 10 are issued in order with correct data, and the pointers wrap at least twice.
REQ-037 reset_n low for 2 cycles while level=3 -> out_wr=0 and level=0 immediately, in_ready=1. No out_wr for 20 cycles after release.
REQ-038 Push coinciding with an issue at level=1 -> level stays 1; the next issue is the new entry, 3 cycles later.
